// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Contents:
//   fetch_state_e    : fetch FSM states (ISSUE, WAIT, DROP)
//   PC_INCR          : byte distance between sequential instruction words
//   DEFAULT_RESET_PC : default first fetch address after reset
//   word_align()     : clears the byte-offset bits of an address

package fetch_pkg;

    // ISSUE : free to request (no response outstanding)
    // WAIT  : one request outstanding, its response will be buffered
    // DROP  : one request outstanding, its response is stale and discarded
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer holding {pc, instr} pairs for decode
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push         : write push_data at the tail
//   push_data    : {pc[31:0], instr[31:0]}
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the buffer; overrides push and pop in the same cycle
//   count        : number of valid entries (0..DEPTH)
//   head_valid   : buffer not empty
//   head_data    : head entry, read straight from storage registers

module fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [63:0]              push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [63:0]              head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop & (count_q != '0) & ~flush;
    // A pop in the same cycle frees the head slot, so a full buffer can still accept.
    assign do_push = push & ~flush & ((count_q != DEPTH_C) | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, memory requests, buffer to decode
//
// Parameters:
//   DEPTH        : instruction buffer entries (power of two, >= 2)
//   RESET_PC     : first fetch address after reset
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   imem_req     : request strobe, always accepted by memory
//   imem_addr    : word address of the request
//   imem_rvalid  : response valid (at least one cycle after the request)
//   imem_rdata   : instruction word qualified by imem_rvalid
//   if_valid     : head of buffer valid for decode
//   if_instr     : head instruction
//   if_pc        : head instruction address
//   if_pc4       : if_pc + 4 (wrapping)
//   id_ready     : decode consumes the head when if_valid & id_ready
//   redirect     : one-cycle pulse, restart fetch at redirect_pc
//   redirect_pc  : new fetch address (low two bits ignored)

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [63:0]   head_data;
    logic          in_flight;
    logic          slot_free;

    // A request in flight owns a buffer slot, so its response always finds room.
    assign in_flight = (state_q != ISSUE);
    assign slot_free = ({1'b0, count} + {{CW{1'b0}}, in_flight}) < DEPTH_EXT;

    assign imem_req  = (state_q == ISSUE) & slot_free & ~redirect & ~rst;
    assign imem_addr = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            case (state_q)
                // An outstanding response is stale: drop it now if it is here,
                // otherwise remember to drop it when it arrives.
                WAIT, DROP: state_d = imem_rvalid ? ISSUE : DROP;
                default:    state_d = ISSUE;
            endcase
        end else begin
            case (state_q)
                ISSUE: begin
                    if (imem_req) begin
                        state_d    = WAIT;
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_INCR;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        push    = 1'b1;
                        state_d = ISSUE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_d = ISSUE;
                    end
                end
                default: state_d = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ISSUE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    assign pop = head_valid & id_ready;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  ({req_pc_q, imem_rdata}),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign if_valid = head_valid;
    assign if_pc    = head_data[63:32];
    assign if_instr = head_data[31:0];
    assign if_pc4   = if_pc + PC_INCR;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference

module tb_fetch_unit;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_req, imem_rvalid, if_valid, id_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc4, redirect_pc;

    logic        w_rst, w_imem_req, w_imem_rvalid, w_if_valid;
    logic [31:0] w_imem_addr, w_imem_rdata, w_if_instr, w_if_pc, w_if_pc4;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
        .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst(w_rst),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
        .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_pc4(w_if_pc4),
        .id_ready(1'b1), .redirect(1'b0), .redirect_pc(32'h0000_0000)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } entry_t;
    typedef struct { int due; logic [31:0] addr; } resp_t;

    // Reference: buffered instructions, next fetch address, and whether a
    // request is in flight and whether its answer is to be thrown away.
    entry_t      mq[$];
    logic [31:0] m_fetch_pc, m_req_pc;
    bit          m_out, m_stale;

    resp_t       mresp[$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    int          checks = 0, errors = 0;
    int          req_cyc[$];
    logic [31:0] req_addr[$];
    logic [31:0] w_req_addr[$], w_pc_seen[$], w_pc4_seen[$];
    bit          w_req_prev;
    logic [31:0] w_addr_prev;
    bit          found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch_pc = 32'h0000_0000;
        m_req_pc   = 32'h0000_0000;
        m_out      = 1'b0;
        m_stale    = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model, then after the
    // rising edge drive the memory responses for the next cycle.
    task automatic cycle();
        bit ereq;
        @(negedge clk);
        ereq = !rst && !m_out && (mq.size() < DEPTH) && !redirect;
        chk("imem_req", 32'(imem_req), 32'(ereq));
        chk("imem_addr", imem_addr, m_fetch_pc);
        chk("if_valid", 32'(if_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_instr", if_instr, mq[0].instr);
            chk("if_pc4", if_pc4, mq[0].pc + 32'd4);
        end
        if (imem_req) begin
            req_cyc.push_back(cyc);
            req_addr.push_back(imem_addr);
            mresp.push_back('{due: cyc + int'($urandom_range(lat_max, lat_min)), addr: imem_addr});
        end
        if (w_imem_req) w_req_addr.push_back(w_imem_addr);
        if (w_if_valid) begin
            w_pc_seen.push_back(w_if_pc);
            w_pc4_seen.push_back(w_if_pc4);
        end
        w_req_prev  = w_imem_req;
        w_addr_prev = w_imem_addr;

        if (!rst) begin
            if (redirect) begin
                mq.delete();
                m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
                if (m_out) begin
                    if (imem_rvalid) begin
                        m_out   = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
            end else begin
                if (mq.size() != 0 && id_ready) void'(mq.pop_front());
                if (imem_rvalid && m_out) begin
                    if (!m_stale) mq.push_back({m_req_pc, imem_rdata});
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end
                if (ereq) begin
                    m_out      = 1'b1;
                    m_req_pc   = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end

        @(posedge clk);
        cyc++;
        #1;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        if (mresp.size() != 0 && mresp[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h2000_0001 + mresp[0].addr;
            void'(mresp.pop_front());
        end
        w_imem_rvalid = w_req_prev;
        w_imem_rdata  = 32'h2000_0001 + w_addr_prev;
    endtask

    initial begin
        rst = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        w_rst = 1'b1; w_imem_rvalid = 1'b0; w_imem_rdata = '0;
        w_req_prev = 1'b0; w_addr_prev = '0;
        model_reset();
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc4", if_pc4, 32'd4);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        cycle();
        cycle();

        // Sequential fetch with 1-cycle memory: one request every 2 cycles.
        rst = 1'b0; id_ready = 1'b1; lat_min = 1; lat_max = 1;
        req_cyc.delete(); req_addr.delete();
        repeat (12) cycle();
        chk("seq_nreq", 32'(req_addr.size() >= 3), 32'd1);
        if (req_addr.size() >= 3) begin
            chk("seq_addr0", req_addr[0], 32'h0);
            chk("seq_addr1", req_addr[1], 32'h4);
            chk("seq_addr2", req_addr[2], 32'h8);
            chk("seq_gap01", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
            chk("seq_gap12", 32'(req_cyc[2] - req_cyc[1]), 32'd2);
        end

        // Decode stalled: buffer fills and requests stop, then drains in order.
        id_ready = 1'b0;
        repeat (10) cycle();
        chk("stall_valid", 32'(if_valid), 32'd1);
        chk("stall_no_req", 32'(imem_req), 32'd0);
        id_ready = 1'b1;
        repeat (8) cycle();

        // Redirect while waiting on a slow response: stale word dropped.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (m_out && !m_stale && !imem_rvalid) found = 1'b1;
        end
        chk("wait_reached", 32'(found), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        req_addr.delete();
        repeat (12) cycle();
        chk("redir_nreq", 32'(req_addr.size() >= 1), 32'd1);
        if (req_addr.size() >= 1) chk("redir_addr", req_addr[0], 32'h0000_0040);

        // Redirect in the same cycle as the response: word not buffered.
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (m_out && imem_rvalid) found = 1'b1;
        end
        chk("coinc_reached", 32'(found), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        chk("coinc_addr", imem_addr, 32'h0000_0100);
        chk("coinc_valid", 32'(if_valid), 32'd0);
        repeat (8) cycle();

        // Randomised traffic: stalls, redirects, variable latency, reset pulses.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom();
            end
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
        end

        // Reset while a request is in flight with an entry buffered.
        id_ready = 1'b1; lat_min = 2; lat_max = 2;
        repeat (12) cycle();
        id_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (m_out && mq.size() == 1 && mresp.size() == 1 && mresp[0].due == cyc + 1) found = 1'b1;
        end
        chk("rstwait_reached", 32'(found), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rstwait_valid", 32'(if_valid), 32'd0);
        chk("rstwait_addr", imem_addr, 32'd0);
        cycle();
        rst = 1'b0; id_ready = 1'b1;
        req_addr.delete();
        repeat (10) cycle();
        chk("rstwait_nreq", 32'(req_addr.size() >= 2), 32'd1);
        if (req_addr.size() >= 2) begin
            chk("rstwait_addr0", req_addr[0], 32'h0);
            chk("rstwait_addr1", req_addr[1], 32'h4);
        end

        // Address wrap from the top of the address space.
        w_rst = 1'b0;
        w_req_addr.delete(); w_pc_seen.delete(); w_pc4_seen.delete();
        repeat (10) cycle();
        chk("wrap_nreq", 32'(w_req_addr.size() >= 3), 32'd1);
        chk("wrap_nvalid", 32'(w_pc_seen.size() >= 3), 32'd1);
        if (w_req_addr.size() >= 3) begin
            chk("wrap_addr0", w_req_addr[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", w_req_addr[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", w_req_addr[2], 32'h0000_0000);
        end
        if (w_pc_seen.size() >= 3) begin
            chk("wrap_pc1", w_pc_seen[1], 32'hFFFF_FFFC);
            chk("wrap_pc4_1", w_pc4_seen[1], 32'h0000_0000);
            chk("wrap_pc2", w_pc_seen[2], 32'h0000_0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
